// File: rtl/sdspi_init_seq_pkg.sv
// sdspi_init_seq_pkg: state encoding and SD command constants for the SPI-mode init sequencer
package sdspi_init_seq_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_WAKE, S_CMD0, S_CMD8, S_CMD55, S_ACMD41, S_CMD58, S_CMD16, S_READY, S_ERROR
  } state_t;
  localparam logic [5:0] CMD_GO_IDLE      = 6'd0;
  localparam logic [5:0] CMD_SEND_IF_COND = 6'd8;
  localparam logic [5:0] CMD_APP          = 6'd55;
  localparam logic [5:0] ACMD_SD_OP_COND  = 6'd41;
  localparam logic [5:0] CMD_READ_OCR     = 6'd58;
  localparam logic [5:0] CMD_SET_BLOCKLEN = 6'd16;
  localparam logic [11:0] CMD8_PATTERN    = 12'h1AA;
  localparam logic [7:0] R1_IDLE          = 8'h01;
  localparam int R1_ILLEGAL_BIT           = 2;
  function automatic logic [5:0] cmd_index(state_t s);
    return s == S_CMD8   ? CMD_SEND_IF_COND :
           s == S_CMD55  ? CMD_APP :
           s == S_ACMD41 ? ACMD_SD_OP_COND :
           s == S_CMD58  ? CMD_READ_OCR :
           s == S_CMD16  ? CMD_SET_BLOCKLEN : CMD_GO_IDLE;
  endfunction
endpackage

// File: rtl/sdspi_init_seq.sv
// sdspi_init_seq: SD SPI-mode power-up sequencer; owns the spicmd command port until init completes
module sdspi_init_seq
  import sdspi_init_seq_pkg::*;
#(
  parameter int WAKE_BYTES = 10,
  parameter int ACMD41_MAX = 1000,
  parameter int TMO_W      = 24
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_host_stb,
  input  logic [1:0]  i_host_type,
  input  logic [5:0]  i_host_cmd,
  input  logic [31:0] i_host_arg,
  output logic        o_host_busy,
  output logic        o_ready,
  output logic        o_err,
  output logic        o_sdhc,
  output logic        o_cmd_stb,
  output logic [1:0]  o_cmd_type,
  output logic [5:0]  o_cmd,
  output logic [31:0] o_cmd_arg,
  output logic        o_cmd_reset,
  input  logic        i_cmd_busy,
  input  logic        i_cmd_rxvalid,
  input  logic [39:0] i_cmd_response,
  input  logic        i_cmd_ll_stb,
  input  logic [7:0]  i_cmd_ll_byte,
  output logic        o_ll_stb,
  output logic [7:0]  o_ll_byte,
  input  logic        i_ll_busy,
  output logic        o_cs_n
);
  localparam int WW = $clog2(WAKE_BYTES + 1);
  localparam int RW = $clog2(ACMD41_MAX + 1);
  state_t r_state, w_next;
  logic r_sent, r_hcs, r_sdhc, r_cmd_reset;
  logic [TMO_W-1:0] r_tmo;
  logic [RW-1:0] r_retry;
  logic [WW-1:0] r_wake;
  logic w_in_cmd, w_ready, w_start, w_issue, w_rx, w_tmo, w_v2, w_unused;
  logic [7:0] w_r1;
  assign w_in_cmd = r_state inside {S_CMD0, S_CMD8, S_CMD55, S_ACMD41, S_CMD58, S_CMD16};
  assign w_ready  = r_state == S_READY;
  assign w_start  = i_start && (r_state inside {S_IDLE, S_READY, S_ERROR});
  assign w_issue  = w_in_cmd && !r_sent && !i_cmd_busy;
  assign w_rx     = w_in_cmd && r_sent && i_cmd_rxvalid;
  assign w_tmo    = w_in_cmd && r_sent && !i_cmd_rxvalid && &r_tmo;
  assign w_r1     = i_cmd_response[39:32];
  assign w_v2     = w_r1 == R1_IDLE && i_cmd_response[11:0] == CMD8_PATTERN;
  assign w_unused = ^{i_cmd_response[31], i_cmd_response[29:12]};
  always_comb begin
    w_next = r_state;
    if (w_start) w_next = S_WAKE;
    else if (w_tmo) w_next = S_ERROR;
    else if (r_state == S_WAKE) w_next = (!i_ll_busy && r_wake == WW'(WAKE_BYTES - 1)) ? S_CMD0 : S_WAKE;
    else if (w_rx)
      case (r_state)
        S_CMD0:   w_next = w_r1 == R1_IDLE ? S_CMD8 : S_ERROR;
        S_CMD8:   w_next = (w_v2 || w_r1[R1_ILLEGAL_BIT]) ? S_CMD55 : S_ERROR;
        S_CMD55:  w_next = w_r1[7:1] == 7'd0 ? S_ACMD41 : S_ERROR;
        S_ACMD41: w_next = w_r1 == 8'h00 ? S_CMD58 :
                           (w_r1 == R1_IDLE && r_retry != RW'(ACMD41_MAX - 1)) ? S_CMD55 : S_ERROR;
        S_CMD58:  w_next = w_r1 != 8'h00 ? S_ERROR : (i_cmd_response[30] && r_hcs) ? S_READY : S_CMD16;
        S_CMD16:  w_next = w_r1 == 8'h00 ? S_READY : S_ERROR;
        default:  w_next = r_state;
      endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_sent      <= 1'b0;
      r_tmo       <= '0;
      r_retry     <= '0;
      r_wake      <= '0;
      r_hcs       <= 1'b0;
      r_sdhc      <= 1'b0;
      r_cmd_reset <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cmd_reset <= w_start || w_tmo;
      r_sent      <= (w_next != r_state) ? 1'b0 : (r_sent || w_issue);
      r_tmo       <= w_issue ? '0 : r_sent ? r_tmo + 1'b1 : r_tmo;
      r_wake      <= w_start ? '0 : (r_state == S_WAKE && !i_ll_busy) ? r_wake + 1'b1 : r_wake;
      r_retry     <= w_start ? '0 : (w_rx && r_state == S_ACMD41) ? r_retry + 1'b1 : r_retry;
      r_hcs       <= w_start ? 1'b0 : (w_rx && r_state == S_CMD8) ? w_v2 : r_hcs;
      r_sdhc      <= w_start ? 1'b0 : (w_rx && r_state == S_CMD58 && w_r1 == 8'h00) ? i_cmd_response[30] && r_hcs : r_sdhc;
    end
  end
  // the host gets the port only once init is done; a restart request wins over a same-cycle host strobe
  assign o_cmd_stb   = w_issue || (w_ready && i_host_stb && !i_cmd_busy && !i_start);
  assign o_cmd       = w_ready ? i_host_cmd : cmd_index(r_state);
  assign o_cmd_type  = w_ready ? i_host_type : (r_state inside {S_CMD8, S_CMD58}) ? 2'b10 : 2'b00;
  assign o_cmd_arg   = w_ready ? i_host_arg :
                       r_state == S_CMD8   ? {20'h0, CMD8_PATTERN} :
                       r_state == S_ACMD41 ? {1'b0, r_hcs, 30'h0} :
                       r_state == S_CMD16  ? 32'd512 : 32'h0;
  assign o_host_busy = w_ready && i_cmd_busy;
  assign o_ready     = w_ready;
  assign o_err       = r_state == S_ERROR;
  assign o_sdhc      = r_sdhc;
  assign o_cmd_reset = r_cmd_reset;
  assign o_ll_stb    = r_state == S_WAKE ? 1'b1 : i_cmd_ll_stb;
  assign o_ll_byte   = r_state == S_WAKE ? 8'hff : i_cmd_ll_byte;
  assign o_cs_n      = r_state inside {S_IDLE, S_WAKE, S_ERROR};
endmodule

// File: tb/tb_sdspi_init_seq.sv
// tb_sdspi_init_seq: card/spicmd model plus sequence-level reference for the SD init sequencer
module tb_sdspi_init_seq;
  localparam int WB = 10, AMAX = 4, TW = 6;
  logic i_clk = 0, i_reset = 1, i_start = 0, i_host_stb = 0;
  logic [1:0] i_host_type = 2'b01;
  logic [5:0] i_host_cmd = 6'd17;
  logic [31:0] i_host_arg = 32'h0000_1234;
  logic o_host_busy, o_ready, o_err, o_sdhc, o_cmd_stb, o_cmd_reset, o_ll_stb, o_cs_n;
  logic [1:0] o_cmd_type;
  logic [5:0] o_cmd;
  logic [31:0] o_cmd_arg;
  logic [7:0] o_ll_byte;
  logic i_cmd_busy = 0, i_cmd_rxvalid = 0, i_cmd_ll_stb = 0, i_ll_busy = 0;
  logic [39:0] i_cmd_response = '0;
  logic [7:0] i_cmd_ll_byte = '0;

  sdspi_init_seq #(.WAKE_BYTES(WB), .ACMD41_MAX(AMAX), .TMO_W(TW)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_host_stb(i_host_stb),
    .i_host_type(i_host_type), .i_host_cmd(i_host_cmd), .i_host_arg(i_host_arg),
    .o_host_busy(o_host_busy), .o_ready(o_ready), .o_err(o_err), .o_sdhc(o_sdhc),
    .o_cmd_stb(o_cmd_stb), .o_cmd_type(o_cmd_type), .o_cmd(o_cmd), .o_cmd_arg(o_cmd_arg),
    .o_cmd_reset(o_cmd_reset), .i_cmd_busy(i_cmd_busy), .i_cmd_rxvalid(i_cmd_rxvalid),
    .i_cmd_response(i_cmd_response), .i_cmd_ll_stb(i_cmd_ll_stb), .i_cmd_ll_byte(i_cmd_ll_byte),
    .o_ll_stb(o_ll_stb), .o_ll_byte(o_ll_byte), .i_ll_busy(i_ll_busy), .o_cs_n(o_cs_n)
  );

  always #5 i_clk = ~i_clk;

  typedef enum {M_IDLE, M_WAKE, M_CMDS, M_READY, M_ERR} mode_t;
  mode_t m_mode = M_IDLE;
  int m_left, m_idx, exp_len;
  bit exp_err, exp_sdhc, m_sdhc;
  int n_checks = 0, n_errors = 0;
  logic [39:0] rec_q[$], exp_q[$];
  int pend = 0, acmd_cnt = 0, n_creset = 0, wake_cnt = 0, cyc = 0, stb_cyc = 0;
  logic [39:0] resp_next;
  logic [7:0] sc_cmd8 = 8'h01;
  int sc_busy_n = 0;
  bit sc_ocr30, sc_silent, first_pend;
  bit st_req, hs_req, rst_req = 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [39:0] card_resp(input logic [39:0] c);
    logic [5:0] idx;
    logic [31:0] arg;
    idx = c[37:32];
    arg = c[31:0];
    case (idx)
      6'd0:    return {8'h01, 32'h0};
      6'd8:    return sc_cmd8 == 8'h01 ? {8'h01, 20'h0, arg[11:0]} : {sc_cmd8, 32'h0};
      6'd55:   return {8'h01, 32'h0};
      6'd41:   return {(acmd_cnt <= sc_busy_n) ? 8'h01 : 8'h00, 32'h0};
      6'd58:   return {8'h00, 1'b1, sc_ocr30, 30'h0};
      6'd16:   return {8'h00, 32'h0};
      default: return {8'h00, 32'hdeadbeef};
    endcase
  endfunction

  task automatic step();
    logic [39:0] e;
    @(negedge i_clk);
    cyc++;
    i_reset = rst_req;
    i_start = st_req; st_req = 0;
    i_host_stb = hs_req; hs_req = 0;
    i_ll_busy = (cyc % 3) == 1;
    i_cmd_ll_stb = (cyc % 2) == 1;
    i_cmd_ll_byte = 8'(cyc) ^ 8'h5a;
    if (pend > 0) begin
      pend--;
      i_cmd_busy = pend != 0;
      i_cmd_rxvalid = pend == 0;
      if (pend == 0) i_cmd_response = resp_next;
    end else begin
      i_cmd_busy = pend < 0;
      i_cmd_rxvalid = 0;
    end
    #1;
    if (!(sc_silent && m_mode == M_CMDS)) begin
      chk("cs_n", o_cs_n, m_mode inside {M_IDLE, M_WAKE, M_ERR});
      chk("ready", o_ready, m_mode == M_READY);
      chk("err", o_err, m_mode == M_ERR);
    end
    chk("sdhc", o_sdhc, m_sdhc);
    if (m_mode == M_WAKE) begin
      chk("wake_ll_stb", o_ll_stb, 1);
      chk("wake_ll_byte", o_ll_byte, 8'hff);
    end else begin
      chk("pass_ll_stb", o_ll_stb, i_cmd_ll_stb);
      chk("pass_ll_byte", o_ll_byte, i_cmd_ll_byte);
    end
    if (m_mode == M_READY) begin
      chk("host_stb", o_cmd_stb, i_host_stb && !i_cmd_busy && !i_start);
      chk("host_busy", o_host_busy, i_cmd_busy);
      if (i_host_stb) chk("host_fields", {o_cmd_type, o_cmd, o_cmd_arg}, {i_host_type, i_host_cmd, i_host_arg});
    end else if (m_mode != M_CMDS || i_cmd_busy) chk("cmd_stb_quiet", o_cmd_stb, 0);
    if (o_cmd_reset) n_creset++;
    if (i_reset || o_cmd_reset) pend = 0;
    else if (o_cmd_stb) begin
      e = {o_cmd_type, o_cmd, o_cmd_arg};
      rec_q.push_back(e);
      if (o_cmd == 6'd41) acmd_cnt++;
      resp_next = card_resp(e);
      pend = sc_silent ? -1 : 4;
      stb_cyc = cyc;
      if (first_pend) begin
        chk("wake_bytes", wake_cnt, WB);
        first_pend = 0;
      end
    end
    if (o_ll_stb && o_ll_byte == 8'hff && !i_ll_busy && o_cs_n) wake_cnt++;
    if (i_reset) begin
      m_mode = M_IDLE;
      m_sdhc = 0;
    end else
      case (m_mode)
        M_IDLE, M_READY, M_ERR:
          if (i_start) begin
            m_mode = M_WAKE; m_left = WB; m_sdhc = 0; wake_cnt = 0; first_pend = 1;
          end
        M_WAKE:
          if (!i_ll_busy) begin
            m_left--;
            if (m_left == 0) begin m_mode = M_CMDS; m_idx = 0; end
          end
        M_CMDS:
          if (i_cmd_rxvalid) begin
            m_idx++;
            if (m_idx == exp_len) begin
              m_mode = exp_err ? M_ERR : M_READY;
              m_sdhc = exp_sdhc;
            end
          end
        default: ;
      endcase
  endtask

  task automatic build(input bit v2, input int pairs, input bit cmd58, input bit cmd16);
    exp_q.delete();
    exp_q.push_back({2'b00, 6'd0, 32'h0});
    exp_q.push_back({2'b10, 6'd8, 32'h0000_01AA});
    repeat (pairs) begin
      exp_q.push_back({2'b00, 6'd55, 32'h0});
      exp_q.push_back({2'b00, 6'd41, v2 ? 32'h4000_0000 : 32'h0});
    end
    if (cmd58) exp_q.push_back({2'b10, 6'd58, 32'h0});
    if (cmd16) exp_q.push_back({2'b00, 6'd16, 32'd512});
  endtask

  task automatic cmp_cmds(input string nm);
    chk({nm, "_ncmds"}, rec_q.size(), exp_q.size());
    for (int i = 0; i < rec_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_cmd%0d", nm, i), rec_q[i], exp_q[i]);
  endtask

  task automatic run_scn(input string nm, input logic [7:0] c8, input int busy_n, input bit ocr30,
                         input bit final_err, input bit sdhc, input bit mid_start);
    bit done, did;
    int base;
    sc_cmd8 = c8; sc_busy_n = busy_n; sc_ocr30 = ocr30; sc_silent = 0; acmd_cnt = 0;
    rec_q.delete();
    exp_len = exp_q.size(); exp_err = final_err; exp_sdhc = sdhc;
    base = n_creset;
    done = 0; did = 0;
    st_req = 1;
    step();
    for (int i = 0; i < 2000 && !done; i++) begin
      if (mid_start && !did && rec_q.size() == 3) begin st_req = 1; did = 1; end
      step();
      done = m_mode == M_READY || m_mode == M_ERR;
    end
    chk({nm, "_done"}, done, 1);
    repeat (3) step();
    cmp_cmds(nm);
    chk({nm, "_cmd_reset_pulses"}, n_creset - base, 1);
    chk({nm, "_sdhc"}, o_sdhc, sdhc);
    chk({nm, "_ready"}, o_ready, !final_err);
    chk({nm, "_err"}, o_err, final_err);
  endtask

  initial begin
    int base;
    bit seen;
    repeat (3) step();
    chk("rst_ready", o_ready, 0);
    chk("rst_err", o_err, 0);
    chk("rst_sdhc", o_sdhc, 0);
    chk("rst_cmd_stb", o_cmd_stb, 0);
    chk("rst_cs_n", o_cs_n, 1);
    chk("rst_cmd_reset", o_cmd_reset, 0);
    rst_req = 0;
    step();
    hs_req = 1; step();
    repeat (3) step();
    chk("idle_host_dropped", rec_q.size(), 0);

    build(1, 4, 1, 0);
    run_scn("v2_sdhc", 8'h01, 3, 1, 0, 1, 0);

    base = rec_q.size();
    hs_req = 1; step();
    hs_req = 1; step();
    repeat (8) step();
    chk("host_ncmds", rec_q.size(), base + 1);
    if (rec_q.size() > base) chk("host_cmd", rec_q[base], {2'b01, 6'd17, 32'h0000_1234});

    build(1, 4, 1, 1);
    run_scn("v2_sdsc", 8'h01, 3, 0, 0, 0, 1);
    build(0, 2, 1, 1);
    run_scn("v1", 8'h05, 1, 1, 0, 0, 0);
    build(1, 4, 0, 0);
    run_scn("acmd_max", 8'h01, 1000, 1, 1, 0, 0);

    exp_q.delete();
    exp_q.push_back({2'b00, 6'd0, 32'h0});
    sc_silent = 1; rec_q.delete(); base = n_creset; seen = 0;
    st_req = 1;
    step();
    for (int i = 0; i < 300 && !seen; i++) begin
      step();
      seen = o_err;
    end
    chk("tmo_err_seen", seen, 1);
    chk("tmo_window", (cyc - stb_cyc) >= 62 && (cyc - stb_cyc) <= 67, 1);
    m_mode = M_ERR;
    repeat (3) step();
    cmp_cmds("tmo");
    chk("tmo_cmd_reset_pulses", n_creset - base, 2);
    chk("tmo_cs_n", o_cs_n, 1);
    sc_silent = 0;

    sc_cmd8 = 8'h01; sc_busy_n = 3; sc_ocr30 = 1; acmd_cnt = 0;
    build(1, 4, 1, 0);
    exp_len = exp_q.size(); exp_err = 0; exp_sdhc = 1;
    rec_q.delete();
    st_req = 1;
    step();
    for (int i = 0; i < 500 && rec_q.size() < 3; i++) step();
    chk("midrst_reached", rec_q.size(), 3);
    rst_req = 1;
    repeat (2) step();
    chk("midrst_cs_n", o_cs_n, 1);
    chk("midrst_ready", o_ready, 0);
    chk("midrst_err", o_err, 0);
    rst_req = 0;
    repeat (6) step();
    chk("midrst_no_cmds", rec_q.size(), 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
